regfile_dump: RTL and testbench

Read-side companion to the switch/button-driven register file write path: on a start pulse it sweeps a range of register file addresses through one read port and streams each register's address and 32-bit contents out of a UART transmitter (8N1). It drives the register file read address and samples the combinational read data. Its serial output connects to the board's USB-UART TX pin for host-side inspection of register contents.

---
 rtl/regfile_dump_if.sv | 23 ++
 rtl/regfile_dump.sv | 149 ++++++++++++++
 tb/tb_regfile_dump.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_if.sv
// Bundle of the register-file read port and the UART dump status signals.
// The dumper sits on the slave side; whoever owns the register file and
// issues start requests sits on the master side.
interface regfile_dump_if;
    logic        start;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  readReg;
    logic [31:0] readData;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (
        output start, first_reg, last_reg, readData,
        input  readReg, tx, busy, done
    );

    modport slave (
        input  start, first_reg, last_reg, readData,
        output readReg, tx, busy, done
    );
endinterface

// File: rtl/regfile_dump.sv
// Register file dumper: sweeps a range of register addresses through one
// read port and streams {address, data} frames out of an 8N1 UART.
// Each register becomes a 5-byte frame: address byte first, then the data
// word most significant byte first. A one-cycle LOAD between registers
// snapshots the read data so later changes cannot corrupt a frame.
module regfile_dump #(
    parameter int BAUD_DIV = 5208
) (
    input  logic          clk,
    input  logic          rst,
    regfile_dump_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    state_t      state;
    state_t      state_next;
    logic [4:0]  read_reg;
    logic [4:0]  last_q;
    logic [39:0] frame;
    logic [2:0]  byte_idx;
    logic [3:0]  bit_idx;
    logic [15:0] baud_cnt;
    logic        busy_q;
    logic        done_q;
    logic        tx_c;
    logic [7:0]  byte_cur;
    logic        bit_end;
    logic        byte_end;
    logic        frame_end;
    logic        last_hit;

    // The byte on the wire is always the top byte; the frame shifts up as bytes finish.
    assign byte_cur = frame[39:32];
    assign last_hit = (read_reg == last_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, serial line value and bit/byte/frame boundary strobes.
    always_comb begin
        state_next = state;
        tx_c       = 1'b1;
        bit_end    = 1'b0;
        byte_end   = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = SEND;
            end
            SEND: begin
                if (bit_idx == 4'd0) begin
                    tx_c = 1'b0;
                end else if (bit_idx == 4'd9) begin
                    tx_c = 1'b1;
                end else begin
                    tx_c = byte_cur[3'(bit_idx - 4'd1)];
                end
                bit_end   = (baud_cnt == BAUD_LAST);
                byte_end  = bit_end && (bit_idx == 4'd9);
                frame_end = byte_end && (byte_idx == 3'd4);
                if (frame_end) begin
                    state_next = last_hit ? IDLE : LOAD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: address sweep, frame snapshot, baud/bit/byte counters, status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_reg <= 5'd0;
            last_q   <= 5'd0;
            frame    <= 40'd0;
            byte_idx <= 3'd0;
            bit_idx  <= 4'd0;
            baud_cnt <= 16'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        read_reg <= bus.first_reg;
                        last_q   <= bus.last_reg;
                        busy_q   <= 1'b1;
                    end
                end
                LOAD: begin
                    frame    <= {3'b000, read_reg, bus.readData};
                    byte_idx <= 3'd0;
                    bit_idx  <= 4'd0;
                    baud_cnt <= 16'd0;
                end
                SEND: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        if (byte_end) begin
                            bit_idx  <= 4'd0;
                            byte_idx <= byte_idx + 3'd1;
                            frame    <= {frame[31:0], 8'h00};
                            if (frame_end) begin
                                if (last_hit) begin
                                    busy_q <= 1'b0;
                                    done_q <= 1'b1;
                                end else begin
                                    read_reg <= read_reg + 5'd1;
                                end
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.readReg = read_reg;
    assign bus.tx      = tx_c;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with BAUD_DIV=4 (201 cycles per register).
// The serial line is recorded cycle by cycle and decoded as 8N1 afterwards.
module tb_regfile_dump;

    localparam int BD = 4;

    logic clk;
    logic rst;

    regfile_dump_if bus ();

    regfile_dump #(.BAUD_DIV(BD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file model with combinational read.
    logic [31:0] regs [32];
    assign bus.readData = regs[bus.readReg];

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests;
    int n_fail;

    logic       tx_h   [0:1023];
    logic       busy_h [0:1023];
    logic       done_h [0:1023];
    logic [4:0] rr_h   [0:1023];
    int         rec_len;
    int         done_cnt;
    int         done_first;
    int         tx_low_cnt;

    logic [7:0] rx     [0:31];
    int         rx_cyc [0:31];
    int         nbytes;

    int          poke_data_cyc;
    int          poke_reg;
    logic [31:0] poke_val;
    int          poke_start_cyc;
    int          poke_clear_cyc;

    // Count one comparison and report it if it disagrees.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a start request that is sampled at the next rising edge (cycle 0).
    task automatic applyStimulus(input logic [4:0] first, input logic [4:0] last, input bit hold);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.first_reg = first;
        bus.last_reg  = last;
        @(posedge clk);
        if (!hold) begin
            #1;
            bus.start = 1'b0;
        end
    endtask

    // Sample outputs at each falling edge; index c is cycle c after the start edge.
    task automatic recordCycles(input int ncyc);
        done_cnt   = 0;
        done_first = -1;
        tx_low_cnt = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            tx_h[c]   = bus.tx;
            busy_h[c] = bus.busy;
            done_h[c] = bus.done;
            rr_h[c]   = bus.readReg;
            if (bus.tx == 1'b0) tx_low_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_first < 0) done_first = c;
            end
            if (c == poke_data_cyc) regs[poke_reg] = poke_val;
            if (c == poke_start_cyc) begin
                bus.start     = 1'b1;
                bus.first_reg = 5'd3;
                bus.last_reg  = 5'd3;
            end
            if (c == poke_start_cyc + 1) bus.start = 1'b0;
            if (c == poke_clear_cyc) bus.start = 1'b0;
        end
        rec_len = ncyc;
    endtask

    // Decode 8N1 bytes from the recorded line, sampling mid-bit.
    task automatic decodeBytes();
        int c;
        logic [7:0] b;
        c      = 1;
        nbytes = 0;
        while ((c + 10 * BD - 1 <= rec_len) && (nbytes < 32)) begin
            if (tx_h[c] == 1'b0) begin
                for (int i = 0; i < 8; i++) b[i] = tx_h[c + (i + 1) * BD + BD / 2];
                rx[nbytes]     = b;
                rx_cyc[nbytes] = c;
                nbytes++;
                c += 10 * BD;
            end else begin
                c++;
            end
        end
    endtask

    task automatic getFrame(input int i, output logic [39:0] v);
        v = {rx[i], rx[i + 1], rx[i + 2], rx[i + 3], rx[i + 4]};
    endtask

    function automatic logic [39:0] expFrame(input logic [4:0] addr, input logic [31:0] data);
        return {3'b000, addr, data};
    endfunction

    logic [39:0] fr;
    logic [4:0]  a;

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        poke_data_cyc  = -1;
        poke_reg       = 0;
        poke_val       = 32'd0;
        poke_start_cyc = -1;
        poke_clear_cyc = -1;
        bus.start      = 1'b0;
        bus.first_reg  = 5'd0;
        bus.last_reg   = 5'd0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;

        // Reset without any clock edge.
        rst = 1'b1;
        #2;
        checkOutput("rst_tx", 64'(bus.tx), 64'd1);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_readReg", 64'(bus.readReg), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        recordCycles(100);
        checkOutput("idle_tx_low_cycles", 64'(tx_low_cnt), 64'd0);

        // Single register.
        regs[5] = 32'hDEADBEEF;
        applyStimulus(5'd5, 5'd5, 1'b0);
        recordCycles(220);
        decodeBytes();
        checkOutput("single_busy_c1", 64'(busy_h[1]), 64'd1);
        checkOutput("single_readReg_c1", 64'(rr_h[1]), 64'd5);
        checkOutput("single_tx_c1", 64'(tx_h[1]), 64'd1);
        checkOutput("single_tx_c2", 64'(tx_h[2]), 64'd0);
        checkOutput("single_nbytes", 64'(nbytes), 64'd5);
        getFrame(0, fr);
        checkOutput("single_frame", 64'(fr), 64'(expFrame(5'd5, 32'hDEADBEEF)));
        checkOutput("single_done_cnt", 64'(done_cnt), 64'd1);
        checkOutput("single_done_cyc", 64'(done_first), 64'd202);
        checkOutput("single_busy_c201", 64'(busy_h[201]), 64'd1);
        checkOutput("single_busy_c202", 64'(busy_h[202]), 64'd0);

        // Wrap-around sweep 30..1.
        for (int i = 0; i < 32; i++) regs[i] = 32'h11110000 + i;
        applyStimulus(5'd30, 5'd1, 1'b0);
        recordCycles(820);
        decodeBytes();
        checkOutput("wrap_nbytes", 64'(nbytes), 64'd20);
        for (int k = 0; k < 4; k++) begin
            a = 5'(30 + k);
            checkOutput($sformatf("wrap_readReg_%0d", k), 64'(rr_h[1 + 201 * k]), 64'(a));
            getFrame(5 * k, fr);
            checkOutput($sformatf("wrap_frame_%0d", k), 64'(fr), 64'(expFrame(a, 32'h11110000 + 32'(a))));
        end
        checkOutput("wrap_second_start_cyc", 64'(rx_cyc[5]), 64'd203);
        checkOutput("wrap_done_cnt", 64'(done_cnt), 64'd1);
        checkOutput("wrap_done_cyc", 64'(done_first), 64'd805);

        // Snapshot and ignored start while busy.
        regs[7]        = 32'hCAFEF00D;
        poke_data_cyc  = 50;
        poke_reg       = 7;
        poke_val       = 32'h0BADBEEF;
        poke_start_cyc = 60;
        applyStimulus(5'd7, 5'd7, 1'b0);
        recordCycles(420);
        poke_data_cyc  = -1;
        poke_start_cyc = -1;
        decodeBytes();
        checkOutput("snap_nbytes", 64'(nbytes), 64'd5);
        getFrame(0, fr);
        checkOutput("snap_frame", 64'(fr), 64'(expFrame(5'd7, 32'hCAFEF00D)));
        checkOutput("snap_done_cnt", 64'(done_cnt), 64'd1);
        checkOutput("snap_done_cyc", 64'(done_first), 64'd202);
        checkOutput("snap_readReg_c100", 64'(rr_h[100]), 64'd7);

        // Back-to-back dumps with start held high.
        regs[2]        = 32'h00C0FFEE;
        poke_clear_cyc = 300;
        applyStimulus(5'd2, 5'd2, 1'b1);
        recordCycles(420);
        poke_clear_cyc = -1;
        checkOutput("b2b_done_c202", 64'(done_h[202]), 64'd1);
        checkOutput("b2b_busy_c202", 64'(busy_h[202]), 64'd0);
        checkOutput("b2b_busy_c203", 64'(busy_h[203]), 64'd1);
        checkOutput("b2b_tx_c203", 64'(tx_h[203]), 64'd1);
        checkOutput("b2b_tx_c204", 64'(tx_h[204]), 64'd0);
        checkOutput("b2b_done_c404", 64'(done_h[404]), 64'd1);
        checkOutput("b2b_done_cnt", 64'(done_cnt), 64'd2);

        // Reset in the middle of bit 4 of byte 2.
        regs[9] = 32'h12345678;
        applyStimulus(5'd9, 5'd9, 1'b0);
        recordCycles(99);
        checkOutput("midrst_tx_before", 64'(tx_h[99]), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_tx", 64'(bus.tx), 64'd1);
        checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
        checkOutput("midrst_readReg", 64'(bus.readReg), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        recordCycles(300);
        decodeBytes();
        checkOutput("midrst_no_done", 64'(done_cnt), 64'd0);
        checkOutput("midrst_no_bytes", 64'(nbytes), 64'd0);
        applyStimulus(5'd9, 5'd9, 1'b0);
        recordCycles(220);
        decodeBytes();
        checkOutput("midrst_again_nbytes", 64'(nbytes), 64'd5);
        getFrame(0, fr);
        checkOutput("midrst_again_frame", 64'(fr), 64'(expFrame(5'd9, 32'h12345678)));
        checkOutput("midrst_again_done_cyc", 64'(done_first), 64'd202);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
